// File: rtl/input_pkg.sv
// Shared definitions for the push-button input path.
//
// Contents:
//   btn_idx_e    - bit position of each button in the N_BUTTONS-wide buses
//   N_BUTTONS    - number of independent button channels
//   rep_state_e  - auto-repeat state per channel
//   DEF_*        - default timing constants derived from the 36 MHz pixel clock
//   max_int      - elaboration-time helper for sizing counters
package input_pkg;

    typedef enum logic [2:0] {
        BTN_C = 3'd0,
        BTN_U = 3'd1,
        BTN_D = 3'd2,
        BTN_R = 3'd3,
        BTN_L = 3'd4
    } btn_idx_e;

    localparam int N_BUTTONS = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rep_state_e;

    localparam int PIXEL_CLK_HZ = 36_000_000;

    // 10 ms debounce, 400 ms before the first repeat, 100 ms repeat period.
    localparam int DEF_DEBOUNCE_CYCLES = PIXEL_CLK_HZ / 100;
    localparam int DEF_REPEAT_DELAY    = (PIXEL_CLK_HZ / 10) * 4;
    localparam int DEF_REPEAT_PERIOD   = PIXEL_CLK_HZ / 10;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_channel.sv
// One button channel: two-flop synchroniser, debouncer, press/release edge
// pulses and the auto-repeat state machine.
//
// Ports:
//   clk           - pixel clock
//   arst          - asynchronous active-high reset
//   raw           - raw asynchronous button pin, 1 = pressed
//   level         - debounced stable level
//   press_pulse   - one-cycle pulse when level rises
//   release_pulse - one-cycle pulse when level falls
//   repeat_pulse  - pulse on press, then auto-repeat pulses while held
module button_channel
    import input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic arst,
    input  logic raw,
    output logic level,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_pulse
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RC_W = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);

    localparam logic [DB_W-1:0] DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RC_W-1:0] DELAY_LAST  = RC_W'(REPEAT_DELAY - 1);
    localparam logic [RC_W-1:0] PERIOD_LAST = RC_W'(REPEAT_PERIOD - 1);

    logic            sync1;
    logic            sync2;
    logic [DB_W-1:0] db_cnt;
    logic            flip;
    logic            rise;
    logic            fall;

    rep_state_e      state;
    rep_state_e      state_next;
    logic [RC_W-1:0] rep_cnt;
    logic [RC_W-1:0] rep_cnt_next;
    logic            repeat_next;

    // The level toggles on the sample that would bring the disagree count
    // to DEBOUNCE_CYCLES; rise/fall are the pending edges of this cycle.
    always_comb begin
        flip = (sync2 != level) && (db_cnt == DB_LAST);
        rise = flip & ~level;
        fall = flip & level;
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            sync1         <= 1'b0;
            sync2         <= 1'b0;
            db_cnt        <= '0;
            level         <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            // Any agreeing sample aborts a pending flip.
            if ((sync2 == level) || flip) begin
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
            level         <= level ^ flip;
            press_pulse   <= rise;
            release_pulse <= fall;
        end
    end

    // Repeat FSM: state register (counter and pulse are registered here too).
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state        <= IDLE;
            rep_cnt      <= '0;
            repeat_pulse <= 1'b0;
        end else begin
            state        <= state_next;
            rep_cnt      <= rep_cnt_next;
            repeat_pulse <= repeat_next;
        end
    end

    // Repeat FSM: next state. A release wins over everything else.
    always_comb begin
        state_next = state;
        if (fall) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (rise) state_next = DELAY;
                DELAY:   if (rep_cnt == DELAY_LAST) state_next = REPEAT;
                REPEAT:  state_next = REPEAT;
                default: state_next = IDLE;
            endcase
        end
    end

    // Repeat FSM: counter and pulse. Counters clear at their terminal value.
    always_comb begin
        rep_cnt_next = '0;
        repeat_next  = 1'b0;
        if (!fall) begin
            case (state)
                IDLE: begin
                    repeat_next = rise;
                end
                DELAY: begin
                    if (rep_cnt == DELAY_LAST) begin
                        repeat_next = 1'b1;
                    end else begin
                        rep_cnt_next = rep_cnt + 1'b1;
                    end
                end
                REPEAT: begin
                    if (rep_cnt == PERIOD_LAST) begin
                        repeat_next = 1'b1;
                    end else begin
                        rep_cnt_next = rep_cnt + 1'b1;
                    end
                end
                default: begin
                    repeat_next = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Conditions the five raw push buttons (c, u, d, r, l) for the game console.
// Each bit is handled by an independent button_channel.
//
// Ports:
//   clk         - pixel clock (36 MHz), the only clock
//   arst        - asynchronous active-high reset
//   btn_raw     - raw button pins, 1 = pressed, bit order per btn_idx_e
//   btn_level   - debounced stable levels
//   btn_press   - one-cycle pulses on level rise
//   btn_release - one-cycle pulses on level fall
//   btn_repeat  - press pulse followed by auto-repeat pulses while held
module button_conditioner
    import input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic                 clk,
    input  logic                 arst,
    input  logic [N_BUTTONS-1:0] btn_raw,
    output logic [N_BUTTONS-1:0] btn_level,
    output logic [N_BUTTONS-1:0] btn_press,
    output logic [N_BUTTONS-1:0] btn_release,
    output logic [N_BUTTONS-1:0] btn_repeat
);

    for (genvar i = 0; i < N_BUTTONS; i++) begin : g_ch
        button_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_channel (
            .clk           (clk),
            .arst          (arst),
            .raw           (btn_raw[i]),
            .level         (btn_level[i]),
            .press_pulse   (btn_press[i]),
            .release_pulse (btn_release[i]),
            .repeat_pulse  (btn_repeat[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
module tb_button_conditioner;

    localparam int NB   = 5;
    localparam int DB   = 4;
    localparam int RD   = 10;
    localparam int RP   = 3;
    localparam int MAXC = 4096;

    logic          clk = 1'b0;
    logic          arst;
    logic [NB-1:0] btn_raw;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] btn_press;
    logic [NB-1:0] btn_release;
    logic [NB-1:0] btn_repeat;

    button_conditioner #(
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk         (clk),
        .arst        (arst),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_repeat  (btn_repeat)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int vfrom = 0;   // first edge whose sample the debouncer may count

    // Reference model state: raw value seen at each edge (0 while in reset),
    // the modelled stable level and the edge of the latest press per button.
    logic [NB-1:0] rec [MAXC];
    logic [NB-1:0] m_level = '0;
    logic [NB-1:0] e_press;
    logic [NB-1:0] e_release;
    logic [NB-1:0] e_repeat;
    int            pt [NB];

    int press_cnt [NB];
    int rel_cnt   [NB];
    int rep_cnt   [NB];

    // The debouncer at edge m sees the raw value captured two edges earlier.
    function automatic logic sample(input int m, input int b);
        if (m < 2) return 1'b0;
        return rec[m-2][b];
    endfunction

    task automatic check(input string tag, input logic [NB-1:0] got, input logic [NB-1:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, got, exp);
        end
    endtask

    task automatic check_int(input string tag, input int got, input int exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, got, exp);
        end
    endtask

    // Level flips when the last DB samples (all since reset) differ from it.
    // Repeats: at the press, then at press+RD+k*RP while the level stays high.
    task automatic step_model();
        e_press   = '0;
        e_release = '0;
        e_repeat  = '0;
        if (arst) begin
            rec[cyc] = '0;
            m_level  = '0;
            vfrom    = cyc + 1;
        end else begin
            rec[cyc] = btn_raw;
            for (int b = 0; b < NB; b++) begin
                logic all_diff;
                all_diff = 1'b1;
                for (int j = 0; j < DB; j++) begin
                    if (((cyc - j) < vfrom) || (sample(cyc - j, b) == m_level[b])) all_diff = 1'b0;
                end
                if (all_diff) begin
                    if (!m_level[b]) begin
                        e_press[b]  = 1'b1;
                        e_repeat[b] = 1'b1;
                        pt[b]       = cyc;
                    end else begin
                        e_release[b] = 1'b1;
                    end
                    m_level[b] = ~m_level[b];
                end else if (m_level[b] && ((cyc - pt[b]) >= RD) && (((cyc - pt[b] - RD) % RP) == 0)) begin
                    e_repeat[b] = 1'b1;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        step_model();
        #1;
        check("level",   btn_level,   m_level);
        check("press",   btn_press,   e_press);
        check("release", btn_release, e_release);
        check("repeat",  btn_repeat,  e_repeat);
        for (int b = 0; b < NB; b++) begin
            if (btn_press[b])   press_cnt[b]++;
            if (btn_release[b]) rel_cnt[b]++;
            if (btn_repeat[b])  rep_cnt[b]++;
        end
        cyc++;
    endtask

    task automatic clear_counts();
        for (int b = 0; b < NB; b++) begin
            press_cnt[b] = 0;
            rel_cnt[b]   = 0;
            rep_cnt[b]   = 0;
        end
    endtask

    initial begin
        for (int b = 0; b < NB; b++) pt[b] = 0;
        clear_counts();
        arst    = 1'b1;
        btn_raw = '0;

        // Reset state
        repeat (3) tick();
        check("rst_level",  btn_level,  5'b00000);
        check("rst_press",  btn_press,  5'b00000);
        check("rst_repeat", btn_repeat, 5'b00000);
        arst = 1'b0;
        repeat (3) tick();

        // Clean press on bit 1: visible after the 6th edge (k+5)
        btn_raw[1] = 1'b1;
        repeat (5) tick();
        tick();
        check("clean_press",  btn_press,  5'b00010);
        check("clean_level",  btn_level,  5'b00010);
        check("clean_repeat", btn_repeat, 5'b00010);
        tick();
        check("clean_press_width", btn_press, 5'b00000);
        btn_raw[1] = 1'b0;
        repeat (10) tick();

        // Glitch rejection on bit 0
        clear_counts();
        btn_raw[0] = 1'b1;
        repeat (3) tick();
        btn_raw[0] = 1'b0;
        repeat (10) tick();
        check_int("glitch3_press", press_cnt[0], 0);
        btn_raw[0] = 1'b1;
        repeat (4) tick();
        btn_raw[0] = 1'b0;
        repeat (12) tick();
        check_int("glitch4_press",   press_cnt[0], 1);
        check_int("glitch4_release", rel_cnt[0],   1);

        // Auto-repeat on bit 3: P, +10, +13, ..., +34 then release at +36
        clear_counts();
        btn_raw[3] = 1'b1;
        repeat (6) tick();
        repeat (30) tick();
        btn_raw[3] = 1'b0;
        repeat (15) tick();
        check_int("autorep_count",   rep_cnt[3], 10);
        check_int("autorep_release", rel_cnt[3], 1);

        // Release coincides with the DELAY terminal count on bit 4
        clear_counts();
        btn_raw[4] = 1'b1;
        repeat (10) tick();
        btn_raw[4] = 1'b0;
        repeat (12) tick();
        check_int("collide_repeat",  rep_cnt[4], 1);
        check_int("collide_release", rel_cnt[4], 1);
        btn_raw[4] = 1'b1;
        repeat (6) tick();
        check("collide_repress", btn_repeat & btn_press, 5'b10000);
        btn_raw[4] = 1'b0;
        repeat (10) tick();

        // Simultaneous presses, staggered releases
        clear_counts();
        btn_raw = 5'h1f;
        repeat (6) tick();
        check("simul_press", btn_press, 5'h1f);
        for (int b = 0; b < NB; b++) begin
            btn_raw[b] = 1'b0;
            repeat (2) tick();
        end
        repeat (10) tick();
        for (int b = 0; b < NB; b++) check_int("simul_release", rel_cnt[b], 1);

        // Asynchronous reset while bit 2 is in REPEAT
        btn_raw[2] = 1'b1;
        repeat (22) tick();
        #2 arst = 1'b1;
        #1;
        check("arst_level",   btn_level,   5'b00000);
        check("arst_press",   btn_press,   5'b00000);
        check("arst_release", btn_release, 5'b00000);
        check("arst_repeat",  btn_repeat,  5'b00000);
        repeat (3) tick();
        arst = 1'b0;
        repeat (5) tick();
        tick();
        check("arst_repress",  btn_press,  5'b00100);
        check("arst_rerepeat", btn_repeat, 5'b00100);
        repeat (14) tick();
        btn_raw[2] = 1'b0;
        repeat (10) tick();

        // Randomised activity against the model
        for (int i = 0; i < 60; i++) begin
            btn_raw = 5'($urandom);
            repeat ($urandom_range(1, 8)) tick();
        end
        btn_raw = '0;
        repeat (20) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
